// File: rtl/uart_avmm_driver.sv
// -----------------------------------------------------------------------------
// uart_avmm_driver
//
// Avalon-MM master that drives the uart_core register interface on behalf of
// byte-stream clients. TX bytes are buffered in a small FIFO and written to the
// core one at a time. Before each write, the core's status register is polled
// until the transmitter reports ready. When the core raises its IRQ, the
// received byte is read and held on a valid/ready RX stream. A fixed number of
// idle cycles (POLL_GAP) precedes every bus access.
//
// Ports:
//   clk_i             system clock
//   rst_n_i           synchronous active-low reset
//   tx_data_i/valid_i TX byte stream in; tx_ready_o = FIFO not full
//   rx_data_o/valid_o RX byte stream out; rx_ready_i = consumer accepts
//   avms_address_o    register address to uart_core
//   avms_read_o       single-cycle read strobe
//   avms_write_o      single-cycle write strobe
//   avms_writedata_o  write data (FIFO head during a write, else 0)
//   avms_readdata_i   read data, valid the cycle after the read strobe
//   irq_i             receive event from uart_core (cleared by RX data read)
//   tx_level_o        FIFO occupancy
//   busy_o            FSM not idle
// -----------------------------------------------------------------------------
module uart_avmm_driver #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned POLL_GAP    = 3,
  parameter logic [3:0]  ADDR_TXDATA = 4'h0,
  parameter logic [3:0]  ADDR_STATUS = 4'h1,
  parameter logic [3:0]  ADDR_RXDATA = 4'h2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [3:0]                    avms_address_o,
  output logic                          avms_read_o,
  output logic                          avms_write_o,
  output logic [7:0]                    avms_writedata_o,
  input  logic [7:0]                    avms_readdata_i,
  input  logic                          irq_i,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
  output logic                          busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : GAP_W'(0);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_POLL,
    S_POLL_WAIT,
    S_WRITE,
    S_RX_RD,
    S_RX_WAIT
  } state_t;

  state_t            state_q, state_d;
  state_t            target_q, target_d;   // state entered when the gap expires
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q;
  // Holds tx_ready_o low during reset and for the release edge, so no byte
  // is accepted until the block has actually come out of reset.
  logic              ready_en_q;

  logic              push;
  logic              pop;
  logic              rx_load;

  // With a zero gap, the target is entered directly.
  function automatic state_t after_gap(input state_t tgt);
    if (POLL_GAP == 0) return tgt;
    return S_GAP;
  endfunction

  assign tx_ready_o = ready_en_q && (level_q < LVL_FULL);
  assign push       = tx_valid_i && tx_ready_o;
  assign tx_level_o = level_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q != S_IDLE);

  // Next-state and bus outputs. Strobes are decoded from the state, so each
  // is high for exactly the one cycle spent in POLL, WRITE or RX_RD.
  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    gap_cnt_d        = gap_cnt_q;
    avms_read_o      = 1'b0;
    avms_write_o     = 1'b0;
    avms_address_o   = ADDR_STATUS;
    avms_writedata_o = 8'h00;
    pop              = 1'b0;
    rx_load          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // RX service wins over TX so received bytes are not left waiting.
        if (irq_i && !rx_valid_q) begin
          state_d   = after_gap(S_RX_RD);
          target_d  = S_RX_RD;
          gap_cnt_d = '0;
        end else if (level_q != '0) begin
          state_d   = after_gap(S_POLL);
          target_d  = S_POLL;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = target_q;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_POLL: begin
        avms_read_o    = 1'b1;
        avms_address_o = ADDR_STATUS;
        state_d        = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        // Not ready: return to IDLE so a pending IRQ can get in before the
        // next poll.
        if (avms_readdata_i[0]) begin
          state_d   = after_gap(S_WRITE);
          target_d  = S_WRITE;
          gap_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        avms_write_o     = 1'b1;
        avms_address_o   = ADDR_TXDATA;
        avms_writedata_o = mem[rd_ptr_q];
        pop              = 1'b1;
        state_d          = S_IDLE;
      end
      S_RX_RD: begin
        avms_read_o    = 1'b1;
        avms_address_o = ADDR_RXDATA;
        state_d        = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        rx_load = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      target_q   <= S_IDLE;
      gap_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      gap_cnt_q  <= gap_cnt_d;
      ready_en_q <= 1'b1;

      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase

      // RX_WAIT is only reachable with the holding register empty, so a load
      // never collides with a consumer handshake.
      if (rx_load) begin
        rx_data_q  <= avms_readdata_i;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // FIFO storage: no reset, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= tx_data_i;
  end

endmodule

// File: tb/tb_uart_avmm_driver.sv
// -----------------------------------------------------------------------------
// tb_uart_avmm_driver
//
// Directed bench for uart_avmm_driver. A small uart_core stand-in answers
// reads one cycle after the strobe: the status register reports ready once a
// scheduled number of polls has gone by, and RX data returns a byte chosen by
// the stimulus. A monitor logs every bus transaction (one line each) with its
// cycle number. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_uart_avmm_driver;

  localparam int FIFO_DEPTH = 8;
  localparam int POLL_GAP   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready = 1'b0;
  logic [3:0] avms_address_o;
  logic       avms_read_o;
  logic       avms_write_o;
  logic [7:0] avms_writedata_o;
  logic [7:0] avms_readdata = 8'hE2;
  logic       irq_q = 1'b0;
  logic [3:0] tx_level_o;
  logic       busy_o;

  uart_avmm_driver #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .POLL_GAP   (POLL_GAP),
    .ADDR_TXDATA(4'h0),
    .ADDR_STATUS(4'h1),
    .ADDR_RXDATA(4'h2)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready_o),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready),
    .avms_address_o  (avms_address_o),
    .avms_read_o     (avms_read_o),
    .avms_write_o    (avms_write_o),
    .avms_writedata_o(avms_writedata_o),
    .avms_readdata_i (avms_readdata),
    .irq_i           (irq_q),
    .tx_level_o      (tx_level_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  // Stimulus-owned controls for the core stand-in.
  int         ready_after = 0;     // status bit0 = 1 once this many polls seen
  logic [7:0] rx_byte = 8'h00;
  int         irq_req_cnt = 0;

  // Core stand-in state.
  int         stat_total = 0;
  int         irq_seen = 0;

  // Registered read data: valid only in the cycle after the strobe, garbage
  // (bit0 = 0) otherwise.
  always @(posedge clk) begin
    if (avms_read_o && avms_address_o == 4'h1) begin
      avms_readdata <= {7'h00, (stat_total >= ready_after)};
      stat_total    <= stat_total + 1;
    end else if (avms_read_o && avms_address_o == 4'h2) begin
      avms_readdata <= rx_byte;
    end else begin
      avms_readdata <= 8'hE2;
    end
    if (avms_read_o && avms_address_o == 4'h2) begin
      irq_q <= 1'b0;
    end else if (irq_req_cnt != irq_seen) begin
      irq_q    <= 1'b1;
      irq_seen <= irq_req_cnt;
    end
  end

  // Bus monitor, sampled mid-cycle.
  int   cyc = 0;
  int   ev_q[$];          // 1 = status read, 2 = RX read, 3 = write
  int   stat_cyc_q[$];
  int   wr_cyc_q[$];
  int   wr_data_q[$];
  int   rx_rd_cnt = 0;
  int   bus_cnt = 0;
  int   overlap_cnt = 0;
  int   long_cnt = 0;
  int   bad_addr_cnt = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (avms_read_o && avms_write_o) overlap_cnt = overlap_cnt + 1;
    if ((avms_read_o && prev_rd) || (avms_write_o && prev_wr)) long_cnt = long_cnt + 1;
    if (avms_read_o || avms_write_o) bus_cnt = bus_cnt + 1;
    if (avms_read_o) begin
      $display("cyc %0d: read  addr %0h", cyc, avms_address_o);
      if (avms_address_o == 4'h1) begin
        ev_q.push_back(1);
        stat_cyc_q.push_back(cyc);
      end else if (avms_address_o == 4'h2) begin
        ev_q.push_back(2);
        rx_rd_cnt = rx_rd_cnt + 1;
      end else begin
        bad_addr_cnt = bad_addr_cnt + 1;
      end
    end
    if (avms_write_o) begin
      $display("cyc %0d: write addr %0h data %02h", cyc, avms_address_o, avms_writedata_o);
      if (avms_address_o == 4'h0) begin
        ev_q.push_back(3);
        wr_cyc_q.push_back(cyc);
        wr_data_q.push_back(int'(avms_writedata_o));
      end else begin
        bad_addr_cnt = bad_addr_cnt + 1;
      end
    end
    prev_rd = avms_read_o;
    prev_wr = avms_write_o;
  end

  int n_checks = 0;
  int n_errors = 0;
  int max_level = 0;
  int ready_at_full = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic acc;
    int   n;
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    do begin
      acc = tx_ready_o;
      tick();
      n++;
      if (int'(tx_level_o) > max_level) max_level = int'(tx_level_o);
      if (int'(tx_level_o) == FIFO_DEPTH && tx_ready_o) ready_at_full++;
    end while (!acc && n < 300);
    tx_valid = 1'b0;
    check_eq("push_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic raise_irq(input logic [7:0] b);
    rx_byte     = b;
    irq_req_cnt = irq_req_cnt + 1;
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n = 0;
    while (wr_data_q.size() < target && n < 600) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, wr_data_q.size() >= target}, 32'd1);
  endtask

  task automatic wait_rx_valid(input string tag);
    int n = 0;
    while (!rx_valid_o && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, rx_valid_o}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_o || tx_level_o != 4'd0) && n < 600) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, !busy_o && tx_level_o == 4'd0}, 32'd1);
  endtask

  task automatic pulse_rx_ready();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    int sb, wb, eb, rb, bad, code;
    logic [7:0] bytes12 [12];
    bytes12 = '{8'h48, 8'h45, 8'h4C, 8'h89, 8'h4F, 8'h5F,
                8'h57, 8'h66, 8'h52, 8'h99, 8'h44, 8'h21};

    // ---- Reset held 3 cycles with tx_valid high
    rst_n    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    repeat (3) tick();
    check_eq("rst_bus_pulses", bus_cnt, 0);
    check_eq("rst_level", {28'd0, tx_level_o}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check_eq("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_addr", {28'd0, avms_address_o}, 32'd1);
    check_eq("rst_wdata", {24'd0, avms_writedata_o}, 32'd0);
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    tick();
    check_eq("rel_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    check_eq("rel_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rel_level", {28'd0, tx_level_o}, 32'd0);

    // ---- Single byte, status not ready twice then ready
    ready_after = stat_total + 2;
    sb = stat_cyc_q.size();
    wb = wr_data_q.size();
    push_byte(8'h48);
    wait_writes(wb + 1, "t2_write_seen");
    repeat (20) tick();
    check_eq("t2_status_reads", stat_cyc_q.size() - sb, 3);
    check_eq("t2_write_count", wr_data_q.size() - wb, 1);
    check_eq("t2_write_data", wr_data_q[wb], 32'h48);
    check_eq("t2_poll_spacing_a", stat_cyc_q[sb+1] - stat_cyc_q[sb], 6);
    check_eq("t2_poll_spacing_b", stat_cyc_q[sb+2] - stat_cyc_q[sb+1], 6);
    check_eq("t2_poll_to_write", wr_cyc_q[wb] - stat_cyc_q[sb+2], 5);
    check_eq("t2_level", {28'd0, tx_level_o}, 32'd0);

    // ---- 12 bytes through an 8-deep FIFO, status always ready
    ready_after = stat_total;
    wb = wr_data_q.size();
    max_level = 0;
    ready_at_full = 0;
    for (int i = 0; i < 12; i++) push_byte(bytes12[i]);
    wait_writes(wb + 12, "t3_writes_seen");
    check_eq("t3_max_level", max_level, FIFO_DEPTH);
    check_eq("t3_ready_at_full", ready_at_full, 0);
    for (int i = 0; i < 12; i++) check_eq($sformatf("t3_byte%0d", i), wr_data_q[wb+i], {24'd0, bytes12[i]});
    bad = 0;
    for (int i = 1; i < 12; i++) if (wr_cyc_q[wb+i] - wr_cyc_q[wb+i-1] != 10) bad++;
    check_eq("t3_spacing_bad", bad, 0);
    wait_idle("t3_drained");

    // ---- IRQ arrives while a TX poll is in progress
    ready_after = stat_total + 1;
    eb = ev_q.size();
    wb = wr_data_q.size();
    push_byte(8'h33);
    repeat (2) tick();
    raise_irq(8'h6E);
    wait_writes(wb + 1, "t4_write_seen");
    code = 0;
    for (int i = 0; i < 4; i++) code = (code << 4) | ev_q[eb+i];
    check_eq("t4_event_count", ev_q.size() - eb, 4);
    check_eq("t4_event_order", code, 32'h1213);
    check_eq("t4_write_data", wr_data_q[wb], 32'h33);
    check_eq("t4_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    check_eq("t4_rx_data", {24'd0, rx_data_o}, 32'h6E);
    repeat (5) tick();
    check_eq("t4_rx_held", {31'd0, rx_valid_o}, 32'd1);
    pulse_rx_ready();
    check_eq("t4_rx_cleared", {31'd0, rx_valid_o}, 32'd0);

    // ---- Holding register full blocks a second IRQ
    raise_irq(8'h1F);
    wait_rx_valid("t5_first_valid");
    check_eq("t5_first_data", {24'd0, rx_data_o}, 32'h1F);
    rb = rx_rd_cnt;
    raise_irq(8'h6E);
    repeat (30) tick();
    check_eq("t5_no_second_read", rx_rd_cnt - rb, 0);
    check_eq("t5_irq_pending", {31'd0, irq_q}, 32'd1);
    check_eq("t5_data_held", {24'd0, rx_data_o}, 32'h1F);
    pulse_rx_ready();
    wait_rx_valid("t5_second_valid");
    check_eq("t5_second_read", rx_rd_cnt - rb, 1);
    check_eq("t5_second_data", {24'd0, rx_data_o}, 32'h6E);
    pulse_rx_ready();
    wait_idle("t5_idle");

    // ---- Reset during POLL_WAIT
    ready_after = 32'h7FFF_FFFF;
    sb = stat_cyc_q.size();
    wb = wr_data_q.size();
    push_byte(8'h77);
    begin
      int n = 0;
      while (!(avms_read_o && avms_address_o == 4'h1) && n < 100) begin
        tick();
        n++;
      end
      check_eq("t6_poll_seen", {31'd0, avms_read_o}, 32'd1);
    end
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("t6_read_low", {31'd0, avms_read_o}, 32'd0);
    check_eq("t6_write_low", {31'd0, avms_write_o}, 32'd0);
    check_eq("t6_busy", {31'd0, busy_o}, 32'd0);
    check_eq("t6_level", {28'd0, tx_level_o}, 32'd0);
    check_eq("t6_addr", {28'd0, avms_address_o}, 32'd1);
    rst_n = 1'b1;
    tick();
    check_eq("t6_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    repeat (40) tick();
    check_eq("t6_no_write", wr_data_q.size() - wb, 0);
    check_eq("t6_no_more_polls", stat_cyc_q.size() - sb, 1);

    // ---- Bus protocol over the whole run
    check_eq("overlap", overlap_cnt, 0);
    check_eq("long_pulse", long_cnt, 0);
    check_eq("bad_addr", bad_addr_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
